// File: rtl/ha_serial_adder_ctrl_pkg.sv
// ha_serial_pkg: shared FSM state encoding and legal WIDTH range for the serial adder
package ha_serial_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/ha_serial_adder_ctrl_cell.sv
// ha_cell: single half-adder cell, two of which form the shared full-adder slice
module ha_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// File: rtl/ha_serial_adder_ctrl.sv
// ha_serial_adder_ctrl: bit-serial LSB-first adder over one half-adder pair; HA_SERIAL_SUB_EN adds a subtract mode
module ha_serial_adder_ctrl
    import ha_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef HA_SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("ha_serial_adder_ctrl: WIDTH out of range");
    end

    logic sub_i;
`ifdef HA_SERIAL_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic             s0, c0, s1, c1, new_c;

    ha_cell ha0 (.x(a_sh_q[0]), .y(b_sh_q[0]), .s(s0), .c(c0));
    ha_cell ha1 (.x(s0),        .y(carry_q),   .s(s1), .c(c1));
    assign new_c = c0 | c1;

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                a_sh_d     = a;
                b_sh_d     = sub_i ? ~b : b;
                carry_d    = sub_i ? ~cin : cin;
                cnt_d      = '0;
                sum_d      = '0;
                cout_d     = 1'b0;
                state_d    = RUN;
                in_ready_d = 1'b0;
                busy_d     = 1'b1;
            end
            RUN: begin
                sum_d   = {s1, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = new_c;
                // hold the counter on the last bit so it never wraps
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cout_d      = new_c;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: if (out_ready) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_ha_serial_adder_ctrl.sv
// tb_ha_serial_adder_ctrl: directed vectors checked against a transaction-level model of the serial adder
module tb_ha_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;
    logic         sub = 1'b0;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    ha_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef HA_SERIAL_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    // model: 0 idle, 1 computing, 2 result waiting
    int       m_phase = 0;
    int       m_left  = 0;
    logic [W:0] m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_res   = sub ? ({1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cin})
                              : ({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                m_left  = W;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
        chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
        if (m_phase == 2) begin
            chk("sum", {24'b0, sum}, {24'b0, m_res[W-1:0]});
            chk("cout", {31'b0, cout}, {31'b0, m_res[W]});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        int n = 0;
        while (!in_ready && n < 40) begin
            cyc(1);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            cyc(1);
            lat++;
        end
        if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input logic [W-1:0] es, input logic ec);
        int lat;
        send(ta, tb, tc, ts);
        wait_out(lat);
        chk({name, "_lat"}, lat, W);
        chk({name, "_sum"}, {24'b0, sum}, {24'b0, es});
        chk({name, "_cout"}, {31'b0, cout}, {31'b0, ec});
        take();
    endtask

    initial begin
        int lat;
        cyc(2);
        rst = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        cyc(1);

        send(8'hFF, 8'h01, 1'b0, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_sum", {24'b0, sum}, 32'd0);
        chk("midrst_cout", {31'b0, cout}, 32'd0);
        cyc(12);

        run_op("basic", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        @(negedge clk);
        chk("basic_idle_after", {31'b0, in_ready}, 32'd1);
        run_op("wrap", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
        run_op("ones_plus1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);

        send(8'h80, 8'h80, 1'b0, 1'b0);
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum", {24'b0, sum}, 32'h00);
            chk("bp_cout", {31'b0, cout}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            cyc(1);
        end
        take();
        @(negedge clk);
        chk("bp_idle_after", {31'b0, in_ready}, 32'd1);

        send(8'h12, 8'h34, 1'b0, 1'b0);
        cyc(2);
        a = 8'h11; b = 8'h11; in_valid = 1'b1;
        cyc(3);
        in_valid = 1'b0;
        wait_out(lat);
        chk("ign_sum", {24'b0, sum}, 32'h46);
        chk("ign_cout", {31'b0, cout}, 32'd0);
        take();

        send(8'h01, 8'h01, 1'b0, 1'b0);
        wait_out(lat);
        a = 8'h22; b = 8'h22; in_valid = 1'b1; out_ready = 1'b1;
        cyc(1);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("both_in_ready", {31'b0, in_ready}, 32'd1);
        chk("both_busy", {31'b0, busy}, 32'd0);
        cyc(1);

`ifdef HA_SERIAL_SUB_EN
        run_op("sub1", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub2", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
`endif
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
